// File: rtl/apb_spi_pkg.sv
// Shared register map, STATUS bit positions and data widths for the APB-to-SPI
// register block and its RX FIFO.
package apb_spi_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 32;
  localparam int TX_W       = 8;
  localparam int RX_W       = 10;

  typedef enum logic [APB_ADDR_W-1:0] {
    REG_CTRL   = 4'h0,
    REG_TXDATA = 4'h4,
    REG_RXDATA = 4'h8,
    REG_STATUS = 4'hC
  } reg_addr_e;

  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_TX_DONE   = 3;
  localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/apb_spi_regs_if.sv
// APB completer bus bundle; the register block takes the slave view, the bench
// drives the master view.
interface apb_spi_regs_if;
  logic                              PSEL;
  logic                              PENABLE;
  logic                              PWRITE;
  logic [apb_spi_pkg::APB_ADDR_W-1:0] PADDR;
  logic [apb_spi_pkg::APB_DATA_W-1:0] PWDATA;
  logic [apb_spi_pkg::APB_DATA_W-1:0] PRDATA;
  logic                              PREADY;
  logic                              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_spi_regs_rx_fifo.sv
// Power-of-two RX FIFO with a combinational head output so a read can return
// the word in the same cycle that pops it.
module spi_rx_fifo import apb_spi_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = RX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/apb_spi_regs.sv
// APB register front-end for an SPI wrapper: CTRL/TXDATA outputs, an RX FIFO
// fed by rx_valid edges, and sticky overflow/tx_done status flags.
module apb_spi_regs import apb_spi_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  apb_spi_regs_if.slave   apb,
  output logic [TX_W-1:0] tx_data,
  output logic            apb_mode,
  input  logic [RX_W-1:0] rx_data,
  input  logic            rx_valid,
  input  logic            tx_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic            ctrl_q, ctrl_d;
  logic [TX_W-1:0] txdata_q, txdata_d;
  logic            ovf_q, ovf_d;
  logic            txdone_q, txdone_d;
  logic            rx_valid_q, tx_valid_q;

  logic [RX_W-1:0]  fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic      access, rd, wr, err, pop, push, tx_edge;
  reg_addr_e addr;
  logic      unused_bits;

  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:8]};

  assign access  = apb.PSEL && apb.PENABLE;
  assign rd      = access && !apb.PWRITE;
  assign wr      = access && apb.PWRITE;
  assign addr    = reg_addr_e'({apb.PADDR[3:2], 2'b00});
  assign push    = rx_valid && !rx_valid_q;
  assign tx_edge = tx_valid && !tx_valid_q;

  always_comb begin
    err = 1'b0;
    if (access) begin
      case (addr)
        REG_CTRL, REG_TXDATA, REG_STATUS: err = 1'b0;
        REG_RXDATA: err = apb.PWRITE || fifo_empty;
        default:    err = 1'b1;
      endcase
    end
  end

  assign pop = rd && !err && (addr == REG_RXDATA);

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RX_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    txdata_d = txdata_q;
    ovf_d    = ovf_q;
    txdone_d = txdone_q;
    if (wr && !err) begin
      case (addr)
        REG_CTRL:   ctrl_d   = apb.PWDATA[0];
        REG_TXDATA: txdata_d = apb.PWDATA[TX_W-1:0];
        REG_STATUS: begin
          if (apb.PWDATA[ST_OVERFLOW]) ovf_d    = 1'b0;
          if (apb.PWDATA[ST_TX_DONE])  txdone_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Hardware set events are applied last so they win over a W1C clear.
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (tx_edge) txdone_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= 1'b0;
      txdata_q   <= '0;
      ovf_q      <= 1'b0;
      txdone_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      txdata_q   <= txdata_d;
      ovf_q      <= ovf_d;
      txdone_q   <= txdone_d;
      rx_valid_q <= rx_valid;
      tx_valid_q <= tx_valid;
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (rd && !err) begin
      case (addr)
        REG_CTRL:   apb.PRDATA = {31'b0, ctrl_q};
        REG_TXDATA: apb.PRDATA = {{(APB_DATA_W-TX_W){1'b0}}, txdata_q};
        REG_RXDATA: apb.PRDATA = {{(APB_DATA_W-RX_W){1'b0}}, fifo_dout};
        REG_STATUS: apb.PRDATA = (APB_DATA_W'(fifo_count) << ST_COUNT_LSB)
                               | {28'b0, txdone_q, ovf_q, fifo_full, fifo_empty};
        default:    apb.PRDATA = '0;
      endcase
    end
  end

  assign apb.PSLVERR = err;
  assign apb.PREADY  = 1'b1;
  assign apb_mode    = ctrl_q;
  assign tx_data     = txdata_q;

endmodule

// File: tb/tb_apb_spi_regs.sv
// Directed bench for apb_spi_regs: register access, RX FIFO ordering/overflow,
// status flag W1C behaviour, error responses and reset abort.
module tb_apb_spi_regs;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       apb_mode;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdata;
  logic        err;

  apb_spi_regs_if bus ();

  apb_spi_regs #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .apb      (bus),
    .tx_data  (tx_data),
    .apb_mode (apb_mode),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Setup cycle, access cycle (outputs sampled mid-cycle), then idle.
  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic e);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    #3;
    data = bus.PRDATA;
    e    = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    $display("APB RD addr=0x%01h data=0x%08h err=%0b", addr, data, e);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data,
                           input bit pulse_tx, output logic [31:0] rd_seen, output logic e);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = data;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    if (pulse_tx) tx_valid = 1'b1;
    #3;
    rd_seen = bus.PRDATA;
    e       = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    tx_valid = 1'b0;
    $display("APB WR addr=0x%01h data=0x%08h err=%0b", addr, data, e);
  endtask

  task automatic rx_push(input logic [9:0] word);
    @(posedge clk); #1;
    rx_data = word; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    $display("RX  push word=0x%03h", word);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] wr_seen;
  logic [9:0]  exp_words [4];
  logic [4:0]  far_addr;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    rx_data = '0; rx_valid = 1'b0; tx_valid = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_apb_mode", {31'b0, apb_mode}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_prdata", bus.PRDATA, 32'd0);
    check("rst_pslverr", {31'b0, bus.PSLVERR}, 32'd0);
    check("rst_pready", {31'b0, bus.PREADY}, 32'd1);

    apb_read(4'hC, rdata, err); check("rst_status", rdata, 32'h1);
    apb_read(4'h0, rdata, err); check("rst_ctrl", rdata, 32'h0);
    apb_read(4'h4, rdata, err); check("rst_txdata", rdata, 32'h0);

    // CTRL / TXDATA write and readback
    apb_write(4'h0, 32'h1, 1'b0, wr_seen, err);
    check("wr_ctrl_err", {31'b0, err}, 32'd0);
    apb_write(4'h4, 32'hFFFF_FFA5, 1'b0, wr_seen, err);
    check("apb_mode_out", {31'b0, apb_mode}, 32'd1);
    check("tx_data_out", {24'b0, tx_data}, 32'hA5);
    apb_read(4'h0, rdata, err); check("ctrl_rb", rdata, 32'h1);
    apb_read(4'h4, rdata, err); check("txdata_rb", rdata, 32'hA5);

    // FIFO ordering
    rx_push(10'h3FF); rx_push(10'h100); rx_push(10'h001);
    apb_read(4'hC, rdata, err); check("status_cnt3", rdata, 32'h30);
    apb_read(4'h8, rdata, err); check("rx0", rdata, 32'h3FF); check("rx0_err", {31'b0, err}, 32'd0);
    apb_read(4'h8, rdata, err); check("rx1", rdata, 32'h100);
    apb_read(4'h8, rdata, err); check("rx2", rdata, 32'h001);
    apb_read(4'hC, rdata, err); check("status_drained", rdata, 32'h1);

    // Overflow: fifth word dropped
    rx_push(10'h011); rx_push(10'h022); rx_push(10'h033); rx_push(10'h044); rx_push(10'h055);
    apb_read(4'hC, rdata, err); check("status_ovf", rdata, 32'h46);
    apb_write(4'hC, 32'h4, 1'b0, wr_seen, err);
    apb_read(4'hC, rdata, err); check("status_ovf_clr", rdata, 32'h42);

    // Push edge coincides with a pop on a full FIFO
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h8;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1; rx_data = 10'h3AA; rx_valid = 1'b1;
    #3;
    check("pushpop_head", bus.PRDATA, 32'h011);
    check("pushpop_err", {31'b0, bus.PSLVERR}, 32'd0);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rx_valid = 1'b0;
    $display("APB RD addr=0x8 with simultaneous RX push word=0x3aa");
    apb_read(4'hC, rdata, err); check("status_pushpop", rdata, 32'h42);
    exp_words[0] = 10'h022; exp_words[1] = 10'h033; exp_words[2] = 10'h044; exp_words[3] = 10'h3AA;
    for (int i = 0; i < 4; i++) begin
      apb_read(4'h8, rdata, err);
      check($sformatf("drain%0d", i), rdata, {22'b0, exp_words[i]});
    end
    apb_read(4'hC, rdata, err); check("status_after_drain", rdata, 32'h1);

    // Error responses leave state untouched
    apb_read(4'h8, rdata, err);
    check("rd_empty_err", {31'b0, err}, 32'd1); check("rd_empty_data", rdata, 32'h0);
    apb_write(4'h8, 32'h155, 1'b0, wr_seen, err);
    check("wr_rx_err", {31'b0, err}, 32'd1); check("wr_rx_prdata", wr_seen, 32'h0);
    apb_read(4'hC, rdata, err); check("status_after_err", rdata, 32'h1);
    // PADDR is 4 bits wide, so 0x10 aliases onto CTRL.
    far_addr = 5'h10;
    apb_read(far_addr[3:0], rdata, err);
    check("alias_err", {31'b0, err}, 32'd0); check("alias_data", rdata, 32'h1);

    // tx_done set, W1C clear, set beating clear, other STATUS bits ignored
    @(posedge clk); #1 tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    apb_read(4'hC, rdata, err); check("tx_done_set", rdata, 32'h9);
    apb_write(4'hC, 32'hFFFF_FFF3, 1'b0, wr_seen, err);
    apb_read(4'hC, rdata, err); check("status_ro_ignored", rdata, 32'h9);
    apb_write(4'hC, 32'h8, 1'b0, wr_seen, err);
    apb_read(4'hC, rdata, err); check("tx_done_clr", rdata, 32'h1);
    apb_write(4'hC, 32'h8, 1'b1, wr_seen, err);
    apb_read(4'hC, rdata, err); check("tx_done_set_wins", rdata, 32'h9);

    // Reset during an access discards FIFO contents and registers
    rx_push(10'h2AB); rx_push(10'h0CD);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h8;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rst_n = 1'b1;
    $display("RST asserted during RXDATA access");
    check("rst_mid_mode", {31'b0, apb_mode}, 32'd0);
    check("rst_mid_tx", {24'b0, tx_data}, 32'd0);
    apb_read(4'hC, rdata, err); check("rst_mid_status", rdata, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
